// File: rtl/otter_cu_fsm_irq.sv
// otter_cu_fsm_irq: multi-cycle OTTER control FSM with prioritised maskable interrupts
module otter_cu_fsm_irq #(
  parameter int NUM_IRQ = 1,
  parameter int MEM_LAT = 1,
  localparam int IRQ_W = $clog2(NUM_IRQ > 1 ? NUM_IRQ : 2)
) (
  input  logic               FSM_clk,
  input  logic               FSM_rst,
  input  logic [6:0]         FSM_ir_opcode,
  input  logic [2:0]         FSM_ir_funct,
  input  logic [NUM_IRQ-1:0] FSM_irq,
  input  logic [NUM_IRQ-1:0] FSM_irq_mask,
  input  logic               FSM_mie,
  output logic               FSM_pc_write,
  output logic               FSM_reg_write,
  output logic               FSM_mem_rden1,
  output logic               FSM_mem_rden2,
  output logic               FSM_mem_we2,
  output logic               FSM_csr_we,
  output logic               FSM_mret_exec,
  output logic               FSM_int_taken,
  output logic [IRQ_W-1:0]   FSM_int_id,
  output logic [2:0]         FSM_state
);
  localparam logic [2:0] INIT = 3'd0, FETCH = 3'd1, EXEC = 3'd2, WB = 3'd3, INTR = 3'd4;
  localparam logic [6:0] OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011, OP_SYS = 7'b1110011;
  localparam logic [1:0] WB_INIT = 2'(MEM_LAT - 1);
  logic [2:0] state, state_n;
  logic [1:0] wb_cnt;
  logic [NUM_IRQ-1:0] pending, eligible;
  logic [IRQ_W-1:0] sel, sel_n;
  logic is_load, is_alu, is_sys, csr_rw, ex, wb_last, decide, take;
  assign is_load = FSM_ir_opcode == OP_LOAD;
  assign is_sys = FSM_ir_opcode == OP_SYS;
  assign is_alu = FSM_ir_opcode inside {7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111};
  assign csr_rw = is_sys && FSM_ir_funct != 3'b000 && !FSM_ir_funct[2];
  assign ex = state == EXEC;
  assign wb_last = state == WB && wb_cnt == 2'd0;
  assign decide = (ex && !is_load) || wb_last;
  assign eligible = (pending | FSM_irq) & FSM_irq_mask;
  assign take = decide && FSM_mie && |eligible;
  assign state_n = state == INIT ? FETCH :
                   state == FETCH ? EXEC :
                   ex && is_load ? WB :
                   decide ? (take ? INTR : FETCH) :
                   state == WB ? WB :
                   state == INTR ? FETCH : INIT;
  // fixed priority: lowest eligible channel wins
  always_comb begin
    sel_n = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) if (eligible[i]) sel_n = IRQ_W'(i);
  end
  // state, load wait counter, sticky pending latches and serviced-id registers
  always_ff @(posedge FSM_clk or posedge FSM_rst) begin
    if (FSM_rst) begin
      state <= INIT;
      wb_cnt <= 2'd0;
      pending <= '0;
      sel <= '0;
      FSM_int_id <= '0;
    end else begin
      state <= state_n;
      wb_cnt <= ex && is_load ? WB_INIT : state == WB && wb_cnt != 2'd0 ? wb_cnt - 2'd1 : wb_cnt;
      pending <= (state == INTR ? pending & ~(NUM_IRQ'(1) << sel) : pending) | FSM_irq;
      if (take) sel <= sel_n;
      if (state == INTR) FSM_int_id <= sel;
    end
  end
  assign FSM_pc_write = (ex && !is_load) || wb_last || state == INTR;
  assign FSM_reg_write = (ex && (is_alu || csr_rw)) || wb_last;
  assign FSM_mem_rden1 = state == FETCH;
  assign FSM_mem_rden2 = ex && is_load;
  assign FSM_mem_we2 = ex && FSM_ir_opcode == OP_STORE;
  assign FSM_csr_we = ex && csr_rw;
  assign FSM_mret_exec = ex && is_sys && FSM_ir_funct == 3'b000;
  assign FSM_int_taken = state == INTR;
  assign FSM_state = state;
endmodule

// File: tb/tb_otter_cu_fsm_irq.sv
// tb_otter_cu_fsm_irq: randomized and directed checks of the control FSM against a cycle-queue model
module tb_otter_cu_fsm_irq;
  localparam logic [6:0] LOAD = 7'b0000011, ADDI = 7'b0010011, SYS = 7'b1110011;
  logic clk = 1'b0, rst = 1'b1, mie = 1'b0;
  logic [6:0] op = ADDI;
  logic [2:0] f3 = 3'b000;
  logic [3:0] irq = 4'b0, mask = 4'b1111;
  logic [1:0] pcw, rw, rd1, rd2, we2, csr, mret, itk;
  logic [1:0] iid [2];
  logic [2:0] st [2];
  logic [12:0] obs [2], exp [2];
  int errors = 0, checks = 0;
  int qb [2][8];
  int ql [2];
  int ml [2] = '{2, 4};
  logic [3:0] pend [2];
  logic [1:0] mid [2], msel [2];
  logic [6:0] ops [12] = '{7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
                          7'b0000011, 7'b0100011, 7'b1100011, 7'b1110011, 7'b0001111, 7'b1111111};

  always #5 clk = ~clk;

  otter_cu_fsm_irq #(.NUM_IRQ(4), .MEM_LAT(2)) ua (
    .FSM_clk(clk), .FSM_rst(rst), .FSM_ir_opcode(op), .FSM_ir_funct(f3), .FSM_irq(irq),
    .FSM_irq_mask(mask), .FSM_mie(mie), .FSM_pc_write(pcw[0]), .FSM_reg_write(rw[0]),
    .FSM_mem_rden1(rd1[0]), .FSM_mem_rden2(rd2[0]), .FSM_mem_we2(we2[0]), .FSM_csr_we(csr[0]),
    .FSM_mret_exec(mret[0]), .FSM_int_taken(itk[0]), .FSM_int_id(iid[0]), .FSM_state(st[0]));
  otter_cu_fsm_irq #(.NUM_IRQ(4), .MEM_LAT(4)) ub (
    .FSM_clk(clk), .FSM_rst(rst), .FSM_ir_opcode(op), .FSM_ir_funct(f3), .FSM_irq(irq),
    .FSM_irq_mask(mask), .FSM_mie(mie), .FSM_pc_write(pcw[1]), .FSM_reg_write(rw[1]),
    .FSM_mem_rden1(rd1[1]), .FSM_mem_rden2(rd2[1]), .FSM_mem_we2(we2[1]), .FSM_csr_we(csr[1]),
    .FSM_mret_exec(mret[1]), .FSM_int_taken(itk[1]), .FSM_int_id(iid[1]), .FSM_state(st[1]));

  assign obs[0] = {st[0], pcw[0], rw[0], rd1[0], rd2[0], we2[0], csr[0], mret[0], itk[0], iid[0]};
  assign obs[1] = {st[1], pcw[1], rw[1], rd1[1], rd2[1], we2[1], csr[1], mret[1], itk[1], iid[1]};

  // expected {pc_write, reg_write, rden1, rden2, we2, csr_we, mret, int_taken} for a cycle kind
  function automatic logic [7:0] exp_sb(int c, logic last, logic [6:0] o, logic [2:0] f);
    case (c)
      1: return 8'b0010_0000;
      3: return last ? 8'b1100_0000 : 8'b0;
      4: return 8'b1000_0001;
      2: begin
        if (o == LOAD) return 8'b0001_0000;
        if (o == 7'b0100011) return 8'b1000_1000;
        if (o inside {7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111}) return 8'b1100_0000;
        if (o == SYS && f == 3'd0) return 8'b1000_0010;
        if (o == SYS && f inside {3'd1, 3'd2, 3'd3}) return 8'b1100_0100;
        return 8'b1000_0000;
      end
      default: return 8'b0;
    endcase
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      ql[k] = 1; qb[k][0] = 0; pend[k] = 4'b0; mid[k] = 2'd0; msel[k] = 2'd0;
    end
  endtask

  task automatic push(int k, int v);
    qb[k][ql[k]] = v;
    ql[k]++;
  endtask

  task automatic sample();
    @(negedge clk);
    for (int k = 0; k < 2; k++) exp[k] = {3'(qb[k][0]), exp_sb(qb[k][0], ql[k] == 1, op, f3), mid[k]};
  endtask

  // advance the model over one clock: each instruction is a list of cycles; its last one decides interrupts
  task automatic tick();
    for (int k = 0; k < 2; k++) begin
      int c;
      logic [3:0] elig;
      c = qb[k][0];
      elig = (pend[k] | irq) & mask;
      if (c == 4) begin
        pend[k] = pend[k] & ~(4'b1 << msel[k]);
        mid[k] = msel[k];
      end
      pend[k] = pend[k] | irq;
      for (int i = 0; i < ql[k] - 1; i++) qb[k][i] = qb[k][i + 1];
      ql[k]--;
      if (c == 2 && op == LOAD) for (int i = 0; i < ml[k]; i++) push(k, 3);
      if (ql[k] == 0) begin
        if ((c == 2 || c == 3) && mie && |elig) begin
          for (int i = 3; i >= 0; i--) if (elig[i]) msel[k] = 2'(i);
          push(k, 4);
        end else begin
          push(k, 1);
          push(k, 2);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    sample();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs[k] !== 13'b0) begin errors++; $display("FAIL reset u%0d: got %b want %b", k, obs[k], 13'b0); end
      checks++;
      if (obs[k] !== exp[k]) begin errors++; $display("FAIL reset_model u%0d: got %b want %b", k, obs[k], exp[k]); end
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_alu();
    int seq [6] = '{1, 2, 1, 2, 1, 2};
    op = ADDI;
    for (int i = 0; i < 6; i++) begin
      sample();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs[k] !== exp[k]) begin errors++; $display("FAIL alu u%0d cyc %0d: got %b want %b", k, i, obs[k], exp[k]); end
      end
      checks++;
      if (int'(st[0]) != seq[i]) begin errors++; $display("FAIL alu_seq cyc %0d: got %0d want %0d", i, st[0], seq[i]); end
      tick();
    end
  endtask

  task automatic test_load();
    logic [5:0] seq [5] = '{6'b001_000, 6'b010_001, 6'b011_000, 6'b011_110, 6'b001_000};
    int j = -1;
    op = LOAD;
    for (int i = 0; i < 16; i++) begin
      sample();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs[k] !== exp[k]) begin errors++; $display("FAIL load u%0d cyc %0d: got %b want %b", k, i, obs[k], exp[k]); end
      end
      if (j < 0 && st[0] == 3'd1) j = 0;
      if (j >= 0 && j < 5) begin
        checks++;
        if ({st[0], pcw[0], rw[0], rd2[0]} !== seq[j]) begin
          errors++; $display("FAIL load_seq step %0d: got %b want %b", j, {st[0], pcw[0], rw[0], rd2[0]}, seq[j]);
        end
        j++;
      end
      tick();
    end
  endtask

  task automatic test_csr();
    logic [2:0] fs [2] = '{3'b010, 3'b000};
    logic [3:0] want [2] = '{4'b1110, 4'b0011};
    op = SYS;
    for (int t = 0; t < 2; t++) begin
      f3 = fs[t];
      for (int i = 0; i < 8; i++) begin
        sample();
        for (int k = 0; k < 2; k++) begin
          checks++;
          if (obs[k] !== exp[k]) begin errors++; $display("FAIL csr u%0d cyc %0d: got %b want %b", k, i, obs[k], exp[k]); end
        end
        if (st[0] == 3'd2) begin
          checks++;
          if ({csr[0], rw[0], pcw[0], mret[0]} !== want[t]) begin
            errors++; $display("FAIL csr_exec f3=%0d: got %b want %b", f3, {csr[0], rw[0], pcw[0], mret[0]}, want[t]);
          end
        end
        tick();
      end
    end
    f3 = 3'b000;
  endtask

  task automatic test_irq();
    logic pulsed = 1'b0;
    logic [2:0] prev = 3'd0;
    logic [3:0] ids = 4'b0;
    int n = 0;
    op = ADDI; mie = 1'b1; mask = 4'b1111;
    for (int i = 0; i < 18; i++) begin
      irq = 4'b0;
      sample();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs[k] !== exp[k]) begin errors++; $display("FAIL irq u%0d cyc %0d: got %b want %b", k, i, obs[k], exp[k]); end
      end
      if (prev == 3'd4) begin ids = {ids[1:0], iid[0]}; n++; end
      prev = st[0];
      if (!pulsed && st[0] == 3'd1) begin irq = 4'b0110; pulsed = 1'b1; end
      tick();
    end
    checks++;
    if (n != 2 || ids !== 4'b0110) begin errors++; $display("FAIL irq_order: got n=%0d ids=%b want n=2 ids=0110", n, ids); end
  endtask

  task automatic test_mask();
    logic pulsed = 1'b0;
    int n = 0;
    mie = 1'b1; mask = 4'b0111; op = ADDI;
    for (int i = 0; i < 22; i++) begin
      irq = 4'b0;
      if (i == 12) mask = 4'b1000;
      sample();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs[k] !== exp[k]) begin errors++; $display("FAIL mask u%0d cyc %0d: got %b want %b", k, i, obs[k], exp[k]); end
      end
      if (st[0] == 3'd4) begin
        n++;
        checks++;
        if (i < 12) begin errors++; $display("FAIL mask_block cyc %0d: got INTR want none", i); end
      end
      if (!pulsed && st[0] == 3'd1) begin irq = 4'b1000; pulsed = 1'b1; end
      tick();
    end
    checks++;
    if (n != 1 || iid[0] !== 2'd3) begin errors++; $display("FAIL mask_service: got n=%0d id=%0d want n=1 id=3", n, iid[0]); end
  endtask

  task automatic test_reset_mid_wb();
    logic [2:0] prev = 3'd0;
    logic hit = 1'b0;
    int n = 0;
    mie = 1'b0; mask = 4'b1111; op = LOAD; irq = 4'b1111;
    for (int i = 0; i < 40 && !hit; i++) begin
      sample();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs[k] !== exp[k]) begin errors++; $display("FAIL midwb u%0d cyc %0d: got %b want %b", k, i, obs[k], exp[k]); end
      end
      if (prev == 3'd3 && st[1] == 3'd3) begin
        rst = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
          checks++;
          if (obs[k] !== 13'b0) begin errors++; $display("FAIL midwb_reset u%0d: got %b want %b", k, obs[k], 13'b0); end
        end
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        hit = 1'b1;
      end else begin
        prev = st[1];
        tick();
        irq = 4'b0;
      end
    end
    checks++;
    if (!hit) begin errors++; $display("FAIL midwb_timeout: got no second WB cycle want one within 40 cycles"); end
    irq = 4'b0; mie = 1'b1; op = ADDI;
    for (int i = 0; i < 10; i++) begin
      sample();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs[k] !== exp[k]) begin errors++; $display("FAIL after_reset u%0d cyc %0d: got %b want %b", k, i, obs[k], exp[k]); end
      end
      if (i < 2) begin
        checks++;
        if (int'(st[0]) != i) begin errors++; $display("FAIL after_reset_seq cyc %0d: got %0d want %0d", i, st[0], i); end
      end
      if (st[0] == 3'd4) n++;
      tick();
    end
    checks++;
    if (n != 0) begin errors++; $display("FAIL pending_cleared: got %0d INTR want 0", n); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      op = ops[$urandom_range(11)];
      f3 = 3'($urandom);
      irq = ($urandom_range(7) == 0) ? 4'($urandom) : 4'b0;
      if (i % 20 == 0) begin mask = 4'($urandom); mie = 1'($urandom); end
      sample();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs[k] !== exp[k]) begin errors++; $display("FAIL random u%0d cyc %0d: got %b want %b", k, i, obs[k], exp[k]); end
      end
      tick();
    end
    irq = 4'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_csr();
    test_irq();
    test_mask();
    test_reset_mid_wb();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
